// File: rtl/seq_decoder_pkg.sv
// rtl/seq_decoder_pkg.sv - mode encoding and one-hot helper shared by the step decoder
package seq_decoder_pkg;

    typedef enum logic {
        MODE_DECODE = 1'b0,
        MODE_SEQ    = 1'b1
    } mode_e;

    // Widest one-hot the helper can build; callers size-cast down to N_OUT.
    localparam int MAX_OUT = 256;

    function automatic logic [MAX_OUT-1:0] onehot(input int unsigned idx, input int unsigned n_out);
        logic [MAX_OUT-1:0] v;
        v = '0;
        if (idx < n_out) begin
            v[idx[7:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/seq_decoder_if.sv
// rtl/seq_decoder_if.sv - control/step bus between instruction decoder and control matrix
interface seq_decoder_if #(
    parameter int SEL_W = 2,
    parameter int N_OUT = 4
);
    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic             load;
    logic             step_clr;
    logic [N_OUT-1:0] z;
    logic [SEL_W-1:0] cnt;
    logic             wrap;

    modport master (
        output en, mode, sel, load, step_clr,
        input  z, cnt, wrap
    );

    modport slave (
        input  en, mode, sel, load, step_clr,
        output z, cnt, wrap
    );
endinterface

// File: rtl/seq_decoder_onehot_dec.sv
// rtl/seq_decoder_onehot_dec.sv - combinational select+enable to one-hot decoder
module onehot_dec
    import seq_decoder_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int N_OUT = 4
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N_OUT-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y = N_OUT'(onehot(32'(sel), N_OUT));
        end
    end

endmodule

// File: rtl/seq_decoder.sv
// rtl/seq_decoder.sv - registered one-hot decoder / T-state sequencer; SEQ_DECODER_OOB_FLAG_EN adds oob_err
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter  int SEL_W     = 2,
    parameter  int LAST_STEP = 2**SEL_W - 1,
    localparam int N_OUT     = LAST_STEP + 1
) (
    input  logic            clk,
    input  logic            rst,
    seq_decoder_if.slave    bus
`ifdef SEQ_DECODER_OOB_FLAG_EN
    ,
    output logic            oob_err
`endif
);

    localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(LAST_STEP);

    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic             act_q, act_d;
    logic             wrap_q, wrap_d;
    logic             in_range;
    mode_e            cur_mode;
`ifdef SEQ_DECODER_OOB_FLAG_EN
    logic             oob_q, oob_d;
`endif

    assign in_range = 32'(bus.sel) <= 32'(LAST_STEP);
    assign cur_mode = mode_e'(bus.mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            act_q  <= 1'b0;
            wrap_q <= 1'b0;
`ifdef SEQ_DECODER_OOB_FLAG_EN
            oob_q  <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            wrap_q <= wrap_d;
`ifdef SEQ_DECODER_OOB_FLAG_EN
            oob_q  <= oob_d;
`endif
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        wrap_d = 1'b0;
`ifdef SEQ_DECODER_OOB_FLAG_EN
        oob_d  = oob_q;
`endif
        if (bus.step_clr) begin
            cnt_d = '0;
            act_d = 1'b0;
`ifdef SEQ_DECODER_OOB_FLAG_EN
            oob_d = 1'b0;
`endif
        end else if (cur_mode == MODE_DECODE) begin
            // Out-of-range select is still captured, but the outputs stay dark.
            cnt_d = bus.sel;
            act_d = bus.en & in_range;
`ifdef SEQ_DECODER_OOB_FLAG_EN
            oob_d = oob_q | ~in_range;
`endif
        end else if (bus.load) begin
            cnt_d = in_range ? bus.sel : '0;
            act_d = 1'b1;
`ifdef SEQ_DECODER_OOB_FLAG_EN
            oob_d = oob_q | ~in_range;
`endif
        end else if (bus.en) begin
            act_d = 1'b1;
            // A stale out-of-range count left by decode mode restarts at 0.
            if (32'(cnt_q) >= 32'(LAST_STEP)) begin
                cnt_d  = '0;
                wrap_d = (cnt_q == LAST_CNT);
            end else begin
                cnt_d = cnt_q + SEL_W'(1);
            end
        end
    end

    onehot_dec #(
        .SEL_W (SEL_W),
        .N_OUT (N_OUT)
    ) u_dec (
        .sel (cnt_q),
        .en  (act_q),
        .y   (bus.z)
    );

    assign bus.cnt  = cnt_q;
    assign bus.wrap = wrap_q;
`ifdef SEQ_DECODER_OOB_FLAG_EN
    assign oob_err  = oob_q;
`endif

endmodule

// File: tb/tb_seq_decoder.sv
// tb/tb_seq_decoder.sv - self-checking bench for seq_decoder (default and 3-bit/LAST_STEP=4 builds)
module tb_seq_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_decoder_if #(.SEL_W(2), .N_OUT(4)) ia ();
    seq_decoder_if #(.SEL_W(3), .N_OUT(5)) ib ();

`ifdef SEQ_DECODER_OOB_FLAG_EN
    logic oob_a, oob_b;
`endif

    seq_decoder #(.SEL_W(2), .LAST_STEP(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
`ifdef SEQ_DECODER_OOB_FLAG_EN
        , .oob_err (oob_a)
`endif
    );

    seq_decoder #(.SEL_W(3), .LAST_STEP(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
`ifdef SEQ_DECODER_OOB_FLAG_EN
        , .oob_err (oob_b)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        int   cnt;
        logic act;
        logic wrap;
        logic oob;
    } mstate_t;

    mstate_t ma;

    // Reference: step index arithmetic modulo the sequence length.
    function automatic mstate_t ref_step(mstate_t s, int last, logic r, logic clr,
                                         logic ld, logic md, logic e, int sel);
        mstate_t n;
        n = s;
        n.wrap = 1'b0;
        if (r) begin
            n = '0;
        end else if (clr) begin
            n.cnt = 0; n.act = 1'b0; n.oob = 1'b0;
        end else if (md == 1'b0) begin
            n.cnt = sel;
            n.act = e && (sel <= last);
            if (sel > last) n.oob = 1'b1;
        end else if (ld) begin
            n.cnt = (sel <= last) ? sel : 0;
            n.act = 1'b1;
            if (sel > last) n.oob = 1'b1;
        end else if (e) begin
            n.wrap = (s.cnt == last);
            n.cnt  = (s.cnt + 1) % (last + 1);
            n.act  = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_z(mstate_t s);
        return s.act ? 4'(1 << s.cnt) : 4'b0000;
    endfunction

    task automatic tick();
        mstate_t n;
        n = ref_step(ma, 3, rst, ia.step_clr, ia.load, ia.mode, ia.en, int'(ia.sel));
        @(posedge clk);
        ma = n;
        #1;
    endtask

    task automatic idle();
        ia.en = 1'b0; ia.mode = 1'b0; ia.sel = '0; ia.load = 1'b0; ia.step_clr = 1'b0;
        ib.en = 1'b0; ib.mode = 1'b0; ib.sel = '0; ib.load = 1'b0; ib.step_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({ia.z, ia.cnt, ia.wrap} !== {4'b0000, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_a z/cnt/wrap=%b/%0d/%b want 0000/0/0", ia.z, ia.cnt, ia.wrap);
        end
        vectors++;
        if ({ib.z, ib.cnt, ib.wrap} !== {5'b00000, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_b z/cnt/wrap=%b/%0d/%b want 00000/0/0", ib.z, ib.cnt, ib.wrap);
        end
`ifdef SEQ_DECODER_OOB_FLAG_EN
        vectors++;
        if ({oob_a, oob_b} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_oob oob=%b%b want 00", oob_a, oob_b);
        end
`endif
    endtask

    task automatic test_decode();
        rst = 1'b0;
        ia.mode = 1'b0; ia.en = 1'b1; ia.sel = 2'd2;
        tick();
        vectors++;
        if ({ia.z, ia.cnt} !== {4'b0100, 2'd2}) begin
            miscompares++;
            $display("FAIL decode_en z/cnt=%b/%0d want 0100/2", ia.z, ia.cnt);
        end
        ia.en = 1'b0;
        tick();
        vectors++;
        if (ia.z !== 4'b0000) begin
            miscompares++;
            $display("FAIL decode_dis z=%b want 0000", ia.z);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] zs [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        logic       ws [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ia.mode = 1'b1; ia.en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if ({ia.z, ia.wrap} !== {zs[i], ws[i]}) begin
                miscompares++;
                $display("FAIL seq_step%0d z/wrap=%b/%b want %b/%b", i, ia.z, ia.wrap, zs[i], ws[i]);
            end
        end
    endtask

    task automatic test_load_hold();
        ia.step_clr = 1'b1;
        tick();
        ia.step_clr = 1'b0; ia.en = 1'b1;
        tick();
        vectors++;
        if ({ia.z, ia.cnt} !== {4'b0010, 2'd1}) begin
            miscompares++;
            $display("FAIL load_pre z/cnt=%b/%0d want 0010/1", ia.z, ia.cnt);
        end
        ia.load = 1'b1; ia.sel = 2'd3; ia.en = 1'b0;
        tick();
        vectors++;
        if ({ia.z, ia.cnt, ia.wrap} !== {4'b1000, 2'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL load z/cnt/wrap=%b/%0d/%b want 1000/3/0", ia.z, ia.cnt, ia.wrap);
        end
        ia.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({ia.z, ia.wrap} !== {4'b1000, 1'b0}) begin
                miscompares++;
                $display("FAIL hold%0d z/wrap=%b/%b want 1000/0", i, ia.z, ia.wrap);
            end
        end
    endtask

    task automatic test_clear();
        ia.mode = 1'b1; ia.en = 1'b1; ia.step_clr = 1'b1;
        tick();
        vectors++;
        if ({ia.z, ia.cnt, ia.wrap} !== {4'b0000, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL clr_beats_wrap z/cnt/wrap=%b/%0d/%b want 0000/0/0", ia.z, ia.cnt, ia.wrap);
        end
        ia.step_clr = 1'b0; ia.load = 1'b1; ia.sel = 2'd3;
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({ia.z, ia.cnt, ia.wrap} !== {4'b0000, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_beats_load z/cnt/wrap=%b/%0d/%b want 0000/0/0", ia.z, ia.cnt, ia.wrap);
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_mode_switch();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ia.mode = 1'b0; ia.en = 1'b1; ia.sel = 2'd2;
        tick();
        vectors++;
        if (ia.z !== 4'b0100) begin
            miscompares++;
            $display("FAIL switch_dec z=%b want 0100", ia.z);
        end
        ia.mode = 1'b1; ia.sel = 2'd0;
        tick();
        vectors++;
        if ({ia.z, ia.cnt} !== {4'b1000, 2'd3}) begin
            miscompares++;
            $display("FAIL switch_seq z/cnt=%b/%0d want 1000/3", ia.z, ia.cnt);
        end
        tick();
        vectors++;
        if ({ia.z, ia.wrap} !== {4'b0001, 1'b1}) begin
            miscompares++;
            $display("FAIL switch_wrap z/wrap=%b/%b want 0001/1", ia.z, ia.wrap);
        end
        idle();
    endtask

    task automatic test_oob();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ib.mode = 1'b0; ib.en = 1'b1; ib.sel = 3'd4;
        tick();
        vectors++;
        if ({ib.z, ib.cnt} !== {5'b10000, 3'd4}) begin
            miscompares++;
            $display("FAIL oob_edge z/cnt=%b/%0d want 10000/4", ib.z, ib.cnt);
        end
        ib.sel = 3'd6;
        tick();
        vectors++;
        if ({ib.z, ib.cnt} !== {5'b00000, 3'd6}) begin
            miscompares++;
            $display("FAIL oob_dec z/cnt=%b/%0d want 00000/6", ib.z, ib.cnt);
        end
        ib.mode = 1'b1; ib.load = 1'b1; ib.sel = 3'd7; ib.en = 1'b0;
        tick();
        vectors++;
        if ({ib.z, ib.cnt} !== {5'b00001, 3'd0}) begin
            miscompares++;
            $display("FAIL oob_load z/cnt=%b/%0d want 00001/0", ib.z, ib.cnt);
        end
        ib.load = 1'b0; ib.en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if ({ib.z, ib.cnt, ib.wrap} !== {5'b00001, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL oob_wrap z/cnt/wrap=%b/%0d/%b want 00001/0/1", ib.z, ib.cnt, ib.wrap);
        end
`ifdef SEQ_DECODER_OOB_FLAG_EN
        vectors++;
        if (oob_b !== 1'b1) begin
            miscompares++;
            $display("FAIL oob_sticky oob_err=%b want 1", oob_b);
        end
`endif
        ib.step_clr = 1'b1;
        tick();
        vectors++;
        if ({ib.z, ib.cnt} !== {5'b00000, 3'd0}) begin
            miscompares++;
            $display("FAIL oob_clr z/cnt=%b/%0d want 00000/0", ib.z, ib.cnt);
        end
`ifdef SEQ_DECODER_OOB_FLAG_EN
        vectors++;
        if (oob_b !== 1'b0) begin
            miscompares++;
            $display("FAIL oob_cleared oob_err=%b want 0", oob_b);
        end
`endif
        idle();
    endtask

    task automatic test_random();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom % 64) == 0;
            ia.step_clr = ($urandom % 16) == 0;
            ia.load     = ($urandom % 4) == 0;
            ia.mode     = ($urandom % 3) != 0;
            ia.en       = ($urandom % 4) != 0;
            ia.sel      = 2'($urandom);
            tick();
            vectors++;
            if ({ia.z, ia.cnt, ia.wrap} !== {exp_z(ma), 2'(ma.cnt), ma.wrap}) begin
                miscompares++;
                $display("FAIL random%0d z/cnt/wrap=%b/%0d/%b want %b/%0d/%b",
                         i, ia.z, ia.cnt, ia.wrap, exp_z(ma), ma.cnt, ma.wrap);
            end
            vectors++;
            if ($countones(ia.z) > 1) begin
                miscompares++;
                $display("FAIL onehot%0d z=%b want at most one bit set", i, ia.z);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        ma = '0;
        rst = 1'b1;
        idle();
        test_reset();
        test_decode();
        test_sequence();
        test_load_hold();
        test_clear();
        test_mode_switch();
        test_oob();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
